// File: rtl/axi_lite_fifo_reader_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite FIFO reader.
package axi_lite_fifo_reader_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int unsigned STAT_EMPTY_BIT = 16;
    localparam int unsigned STAT_FULL_BIT  = 17;
    localparam int unsigned STAT_OVF_BIT   = 18;
    localparam int unsigned STAT_UDF_BIT   = 19;

    localparam int unsigned CTRL_FLUSH_BIT = 0;
    localparam int unsigned CTRL_CLR_BIT   = 1;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_lite_fifo_reader_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; a full FIFO accepts a push only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     push_dropped
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty        = (count == '0);
    assign full         = (count == FULL_CNT);
    // Flush overrides both sides; the head is still visible this cycle for a concurrent read.
    assign do_pop       = pop && !empty && !flush;
    assign do_push      = push && !flush && (!full || do_pop);
    assign push_dropped = push && !flush && full && !do_pop;
    assign dout         = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_lite_fifo_reader.sv
// AXI4-Lite slave draining a producer FIFO: DATA pops, STATUS reports, CTRL flushes/clears, SCRATCH is RW.
module axi_lite_fifo_reader
    import axi_lite_fifo_reader_pkg::*;
#(
    parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S00_AXI_ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH           = 16,
    parameter int unsigned IN_WIDTH             = 32
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic                              in_valid,
    input  logic [IN_WIDTH-1:0]               in_data,
    output logic                              fifo_full,
    output logic                              fifo_empty,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t      w_state, w_next;
    rd_state_t      r_state, r_next;
    logic           ready_en;
    logic           aw_done, w_done;
    logic [1:0]     aw_idx_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic           aw_hs, w_hs, ar_hs, do_write;
    logic [1:0]     wr_idx;
    logic [31:0]    wr_data;
    logic [3:0]     wr_strb;
    logic           flush, clr_sticky, rd_data_req;
    logic [31:0]    scratch, status_word, head_word, rd_mux;
    logic           overflow, underflow;
    logic [IN_WIDTH-1:0] fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           push_dropped;
    logic           unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    // Readies stay low until the first clock after reset release.
    assign s00_axi_awready = ready_en && (w_state == W_IDLE) && !aw_done;
    assign s00_axi_wready  = ready_en && (w_state == W_IDLE) && !w_done;
    assign s00_axi_bvalid  = (w_state == W_RESP);
    assign s00_axi_bresp   = AXI_RESP_OKAY;
    assign s00_axi_arready = ready_en && (r_state == R_IDLE);
    assign s00_axi_rvalid  = (r_state == R_DATA);
    assign s00_axi_rresp   = AXI_RESP_OKAY;

    assign aw_hs   = s00_axi_awvalid && s00_axi_awready;
    assign w_hs    = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs   = s00_axi_arvalid && s00_axi_arready;
    assign wr_idx  = aw_done ? aw_idx_q : s00_axi_awaddr[3:2];
    assign wr_data = w_done ? wdata_q : s00_axi_wdata;
    assign wr_strb = w_done ? wstrb_q : s00_axi_wstrb;
    assign rd_data_req = ar_hs && (s00_axi_araddr[3:2] == REG_DATA);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_next   = w_state;
        do_write = 1'b0;
        case (w_state)
            W_IDLE: if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                do_write = 1'b1;
                w_next   = W_RESP;
            end
            W_RESP: if (s00_axi_bready) w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_next = R_DATA;
            R_DATA: if (s00_axi_rready) r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (do_write) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_done  <= 1'b1;
                aw_idx_q <= s00_axi_awaddr[3:2];
            end
            if (w_hs) begin
                w_done  <= 1'b1;
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
        end
    end

    always_comb begin
        flush      = 1'b0;
        clr_sticky = 1'b0;
        if (do_write && wr_idx == REG_CTRL) begin
            flush      = wr_data[CTRL_FLUSH_BIT];
            clr_sticky = wr_data[CTRL_CLR_BIT];
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            scratch <= '0;
        end else if (do_write && wr_idx == REG_SCRATCH) begin
            for (int unsigned b = 0; b < 4; b++)
                if (wr_strb[b]) scratch[8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // A new event in the same cycle as a clear leaves the flag set.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_dropped)                   overflow  <= 1'b1;
            else if (clr_sticky)                overflow  <= 1'b0;
            if (rd_data_req && fifo_empty)      underflow <= 1'b1;
            else if (clr_sticky)                underflow <= 1'b0;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[15:0]           = 16'(fifo_count);
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_OVF_BIT]   = overflow;
        status_word[STAT_UDF_BIT]   = underflow;
        head_word = '0;
        head_word[IN_WIDTH-1:0] = fifo_dout;
        case (s00_axi_araddr[3:2])
            REG_DATA:    rd_mux = fifo_empty ? '0 : head_word;
            REG_STATUS:  rd_mux = status_word;
            REG_SCRATCH: rd_mux = scratch;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)
            s00_axi_rdata <= '0;
        else if (ar_hs)
            s00_axi_rdata <= rd_mux;
    end

    sync_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (s00_axi_aclk),
        .rst_n        (s00_axi_aresetn),
        .push         (in_valid),
        .pop          (rd_data_req),
        .flush        (flush),
        .din          (in_data),
        .dout         (fifo_dout),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .push_dropped (push_dropped)
    );

endmodule

// File: tb/tb_axi_lite_fifo_reader.sv
// Directed and randomized bench for axi_lite_fifo_reader against a queue-based reference model.
module tb_axi_lite_fifo_reader;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        fifo_full, fifo_empty;
    logic [3:0]  awaddr = '0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic        arvalid = 1'b0, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready = 1'b0;

    always #5 clk = ~clk;

    axi_lite_fifo_reader #(
        .C_S00_AXI_DATA_WIDTH (32),
        .C_S00_AXI_ADDR_WIDTH (4),
        .FIFO_DEPTH           (DEPTH),
        .IN_WIDTH             (32)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (3'b000),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (3'b000),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model: a plain queue plus sticky flags, advanced at each falling edge for the next rising edge.
    logic [31:0] m_q[$];
    logic [31:0] exp_rd[$];
    logic        m_ovf, m_udf;
    logic [31:0] m_scratch;
    logic        m_aw_have, m_w_have;
    logic [3:0]  m_aw_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        rand_push = 1'b0;

    always @(negedge clk) begin : model
        logic        aw_go, w_go, ar_go, commit, flush, clr, pop, was_full;
        logic [3:0]  waddr, ws;
        logic [31:0] wd, e;
        if (!rst_n) begin
            m_q.delete();
            exp_rd.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_scratch = '0;
            m_aw_have = 1'b0; m_w_have = 1'b0;
        end else begin
            chk("fifo_empty", fifo_empty, m_q.size() == 0);
            chk("fifo_full", fifo_full, m_q.size() == DEPTH);
            aw_go  = awvalid && awready;
            w_go   = wvalid && wready;
            ar_go  = arvalid && arready;
            commit = (m_aw_have || aw_go) && (m_w_have || w_go);
            waddr  = m_aw_have ? m_aw_addr : awaddr;
            wd     = m_w_have ? m_wdata : wdata;
            ws     = m_w_have ? m_wstrb : wstrb;
            if (commit) begin
                m_aw_have = 1'b0; m_w_have = 1'b0;
            end else begin
                if (aw_go) begin m_aw_have = 1'b1; m_aw_addr = awaddr; end
                if (w_go) begin m_w_have = 1'b1; m_wdata = wdata; m_wstrb = wstrb; end
            end
            if (ar_go) begin
                case (araddr[3:2])
                    2'd0: e = (m_q.size() > 0) ? m_q[0] : 32'h0;
                    2'd1: e = {12'h0, m_udf, m_ovf, m_q.size() == DEPTH, m_q.size() == 0, 16'(m_q.size())};
                    2'd2: e = 32'h0;
                    default: e = m_scratch;
                endcase
                exp_rd.push_back(e);
            end
            flush = commit && waddr[3:2] == 2'd2 && wd[0];
            clr   = commit && waddr[3:2] == 2'd2 && wd[1];
            if (commit && waddr[3:2] == 2'd3)
                for (int i = 0; i < 4; i++)
                    if (ws[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
            pop = ar_go && araddr[3:2] == 2'd0;
            if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
            if (pop && m_q.size() == 0) m_udf = 1'b1;
            if (flush) begin
                m_q.delete();
            end else begin
                was_full = (m_q.size() == DEPTH);
                if (pop && m_q.size() > 0) void'(m_q.pop_front());
                if (in_valid) begin
                    if (!was_full || pop) m_q.push_back(in_data);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic tick_in();
        if (rand_push) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, input string tag, output logic [31:0] data);
        int unsigned n;
        logic [31:0] e;
        araddr = addr;
        arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 100) begin
            @(posedge clk); #1; tick_in();
            @(negedge clk);
            n++;
        end
        chk({tag, " arready"}, arready, 1);
        if (!arready) begin
            arvalid = 1'b0;
            data = '0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        tick_in();
        n = 0;
        while (!rvalid && n < 100) begin
            @(posedge clk); #1; tick_in(); n++;
        end
        chk({tag, " rvalid"}, rvalid, 1);
        chk({tag, " rresp"}, rresp, 0);
        data = rdata;
        chk({tag, " scoreboard"}, exp_rd.size() > 0, 1);
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'h0;
        chk({tag, " rdata"}, data, e);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1; tick_in();
            chk({tag, " rdata hold"}, rdata, data);
        end
        rready = 1'b1;
        @(posedge clk); #1; tick_in();
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int unsigned aw_lead, input int unsigned hold_b,
                             input logic push_too, input logic [31:0] push_data);
        int unsigned c, n;
        logic aw_go, w_go, w_started;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1;
        w_started = (aw_lead == 0);
        wvalid = w_started;
        if (push_too) begin in_valid = 1'b1; in_data = push_data; end
        c = 0;
        while ((awvalid || wvalid || !w_started) && c < 100) begin
            @(negedge clk);
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge clk); #1; tick_in();
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            c++;
            if (!w_started && c >= aw_lead) begin wvalid = 1'b1; w_started = 1'b1; end
        end
        if (push_too) in_valid = 1'b0;
        chk("aw/w accepted", {30'h0, awvalid, wvalid}, 0);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 100) begin
            @(posedge clk); #1; tick_in(); n++;
        end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, 0);
        for (int unsigned i = 0; i < hold_b; i++) begin
            @(posedge clk); #1; tick_in();
            chk("bvalid held", bvalid, 1);
        end
        bready = 1'b1;
        @(posedge clk); #1; tick_in();
        bready = 1'b0;
        chk("bvalid cleared", bvalid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int unsigned sel, n;

        repeat (3) @(negedge clk);
        chk("rst awready", awready, 0);
        chk("rst wready", wready, 0);
        chk("rst arready", arready, 0);
        chk("rst bvalid", bvalid, 0);
        chk("rst rvalid", rvalid, 0);
        chk("rst rdata", rdata, 0);
        chk("rst bresp/rresp", {bresp, rresp}, 0);
        chk("rst empty/full", {fifo_empty, fifo_full}, 2'b10);
        @(posedge clk); #1;
        rst_n = 1'b1;

        axi_read(4'h4, "status idle", d);      chk("status idle const", d, 32'h0001_0000);
        axi_read(4'h0, "data empty", d);       chk("data empty const", d, 32'h0);
        axi_read(4'h4, "status udf", d);       chk("status udf const", d, 32'h0009_0000);
        axi_write(4'h8, 32'h2, 4'hF, 0, 0, 1'b0, 0);

        push_word(32'h11); push_word(32'h22); push_word(32'h33);
        axi_read(4'h0, "data0", d);            chk("data0 const", d, 32'h11);
        axi_read(4'h0, "data1", d);            chk("data1 const", d, 32'h22);
        axi_read(4'h0, "data2", d);            chk("data2 const", d, 32'h33);
        axi_read(4'h4, "status drained", d);   chk("status drained const", d, 32'h0001_0000);

        for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i));
        axi_read(4'h4, "status ovf", d);       chk("status ovf const", d, 32'h0006_0010);
        axi_write(4'h8, 32'h2, 4'hF, 0, 0, 1'b0, 0);
        axi_read(4'h4, "status clr", d);       chk("status clr const", d, 32'h0002_0010);

        in_valid = 1'b1; in_data = 32'hABC;
        araddr = 4'h0; arvalid = 1'b1;
        @(negedge clk);
        chk("full+pop arready", arready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; arvalid = 1'b0;
        chk("full+pop rvalid", rvalid, 1);
        chk("full+pop rdata", rdata, 32'h100);
        chk("full+pop scoreboard", exp_rd.size(), 1);
        if (exp_rd.size() > 0) chk("full+pop model", rdata, exp_rd.pop_front());
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
        axi_read(4'h4, "status full+pop", d);  chk("status full+pop const", d, 32'h0002_0010);
        axi_write(4'h8, 32'h3, 4'hF, 0, 0, 1'b0, 0);

        axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, 2, 3, 1'b0, 0);
        axi_write(4'hC, 32'h0000_0055, 4'h1, 0, 0, 1'b0, 0);
        axi_read(4'hC, "scratch", d);          chk("scratch const", d, 32'hDEAD_BE55);
        axi_read(4'h8, "ctrl reads 0", d);     chk("ctrl const", d, 32'h0);

        for (int i = 0; i < 5; i++) push_word(32'h200 + 32'(i));
        axi_write(4'h8, 32'h1, 4'hF, 0, 0, 1'b1, 32'h999);
        axi_read(4'h4, "status flushed", d);   chk("status flushed const", d, 32'h0001_0000);

        rand_push = 1'b1;
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                axi_read({2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))}, "rand read", d);
            end else if (sel <= 8) begin
                axi_write({2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))}, $urandom, 4'($urandom),
                          $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 0);
            end else begin
                n = $urandom_range(1, 4);
                repeat (n) begin tick_in(); @(posedge clk); #1; end
            end
        end
        rand_push = 1'b0;
        in_valid = 1'b0;
        axi_write(4'h8, 32'h3, 4'hF, 0, 0, 1'b0, 0);

        push_word(32'h300); push_word(32'h301);
        araddr = 4'h0; arvalid = 1'b1;
        @(negedge clk);
        chk("midrst arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("midrst rvalid before", rvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst rvalid drop", rvalid, 0);
        chk("midrst arready low", arready, 0);
        chk("midrst empty", fifo_empty, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst arready pending", arready, 0);
        @(posedge clk); #1;
        chk("post-rst arready", arready, 1);
        axi_read(4'h4, "status post-rst", d);  chk("status post-rst const", d, 32'h0001_0000);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
